// File: rtl/gray_step_sched.sv
// Round-robin scheduler sharing one Gray-coded step counter among N_REQ
// requesters. The winner of an arbitration owns the counter for Len steps,
// one step per cycle, then releases it through a one-cycle DONE state.
module gray_step_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CW    = 3,
  parameter int unsigned LW    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*LW-1:0]       i_len,
  output logic [N_REQ-1:0]          o_grant,
  output logic [$clog2(N_REQ)-1:0]  o_owner,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted,
  output logic [CW-1:0]             o_output,
  output logic                      o_overflow
);

  localparam int unsigned OW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [CW-1:0]   r_bin,     w_bin_nxt;
  logic [LW-1:0]   r_rem,     w_rem_nxt;
  logic [OW-1:0]   r_rr,      w_rr_nxt;
  logic [N_REQ-1:0] r_grant,  w_grant_nxt;
  logic [OW-1:0]   r_owner,   w_owner_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;
  logic            r_aborted, w_aborted_nxt;
  logic            r_ovf,     w_ovf_nxt;
  logic [CW-1:0]   r_gray,    w_gray_nxt;
  logic            w_found;
  logic [OW-1:0]   w_win;

  // Round-robin search: first set request at or above the rr pointer, with wrap
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[OW'(r_rr + OW'(i))]) begin
        w_found = 1'b1;
        w_win   = OW'(r_rr + OW'(i));
      end
    end
  end

  // Next-state and next-output logic; Done defaults low so it pulses once
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_rem_nxt     = r_rem;
    w_rr_nxt      = r_rr;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = r_aborted;
    w_ovf_nxt     = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_RUN;
          w_grant_nxt   = N_REQ'(1) << w_win;
          w_owner_nxt   = w_win;
          w_busy_nxt    = 1'b1;
          w_rem_nxt     = i_len[LW*int'(w_win) +: LW];
          w_ovf_nxt     = 1'b0;
          w_aborted_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (!i_req[r_owner]) begin
          w_state_nxt   = S_DONE;
          w_aborted_nxt = 1'b1;
        end else if (r_rem == '0) begin
          w_state_nxt   = S_DONE;
          w_aborted_nxt = 1'b0;
        end else begin
          w_bin_nxt = r_bin + CW'(1);
          w_rem_nxt = r_rem - LW'(1);
          if (r_bin == {CW{1'b1}}) begin
            w_ovf_nxt = 1'b1;
          end
          if (r_rem == LW'(1)) begin
            w_state_nxt   = S_DONE;
            w_aborted_nxt = 1'b0;
          end
        end
        if (w_state_nxt == S_DONE) begin
          w_done_nxt  = 1'b1;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_rr_nxt    = r_owner + OW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  end

  // State and output registers; synchronous reset clears everything
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_rem     <= '0;
      r_rr      <= '0;
      r_grant   <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_ovf     <= 1'b0;
      r_gray    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_rem     <= w_rem_nxt;
      r_rr      <= w_rr_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_ovf     <= w_ovf_nxt;
      r_gray    <= w_gray_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_owner    = r_owner;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;
  assign o_output   = r_gray;
  assign o_overflow = r_ovf;

endmodule

// File: doc/gray_step_sched.md
Name: gray_step_sched

Overview:
- Round-robin scheduler that shares one 3-bit-style Gray-code step counter among N_REQ requesters.
- Each requester asks for a run of Len steps. The block grants one owner at a time, advances the embedded counter one step per cycle for that owner, and reports the Gray value and wrap-around.
- It sits between requesting control FSMs and the Gray-coded position consumer, replacing a free-running En-gated counter.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..8.
- CW, 3, counter width in bits; the Gray output has the same width.
- LW, 4, width of each per-requester step-count field.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Req  input  N_REQ  per-requester request level; must be held for the whole run.
- Len  input  N_REQ*LW  packed step counts; field i is Len[i*LW +: LW], sampled only at grant.
- Grant  output  N_REQ  one-hot current owner; all zero when no owner.
- Owner  output  clog2(N_REQ)  index of current/last owner.
- Busy  output  1  high while in RUN.
- Done  output  1  single-cycle pulse when a run ends (normal or aborted).
- Aborted  output  1  valid with Done; 1 if the run ended by Req drop.
- Output  output  CW  Gray code of the internal binary count.
- Overflow  output  1  sticky: counter wrapped during the current or most recent run.

Behaviour:
- Reset (sync, active-high, dominates everything):
  - State IDLE; binary count 0; remaining 0; rr pointer 0.
  - Grant, Owner, Busy, Done, Aborted, Output and Overflow all 0.
  - Reset in mid-run aborts the run with no Done pulse.
- Output:
  - Registered; always equals bin ^ (bin >> 1) of the post-edge binary count.
  - Binary count is modulo 2^CW and persists across grants; only Reset clears it.
- State IDLE:
  - If Req != 0 at an edge, pick the first set bit searching from the rr pointer upward with wrap.
  - At that same edge: Grant = onehot(winner), Owner = winner, Busy = 1, remaining = Len field of winner, Overflow = 0, Aborted = 0. Go to RUN.
  - If Req == 0, stay in IDLE; all outputs hold.
- State RUN, evaluated in this priority order:
  1. Req[Owner] == 0: go to DONE with Aborted = 1; no step.
  2. remaining == 0: go to DONE with Aborted = 0; no step. This covers Len = 0.
  3. Otherwise step: bin += 1, remaining -= 1. If bin was 2^CW-1 (wraps to 0), set Overflow = 1. If remaining was 1, go to DONE with Aborted = 0.
  - Latency: for Len = L > 0, granted at edge e0, steps occur at edges e1..eL and DONE is entered at eL. For Len = 0, DONE is entered at e1.
  - Changes to Req of non-owners and to Len during RUN are ignored.
- State DONE (exactly one cycle):
  - Done = 1, Grant = 0, Busy = 0.
  - Owner, Overflow, Aborted and Output hold.
  - rr pointer = (Owner + 1) mod N_REQ.
  - Next edge: Done = 0, go to IDLE.
- Request-to-grant gap: a new grant occurs no earlier than 2 edges after DONE is entered (DONE, then IDLE arbitration). The just-served requester gets lowest priority at the next arbitration.
- Overflow and Aborted stay stable from DONE until the next grant clears them.

Test Plan:
- Reset, then Req=0001, Len0=3 → Grant=0001 one cycle after Req; Output steps 1,3,2 on consecutive cycles; Done=1 next cycle with Aborted=0, Overflow=0, Busy=0.
- From bin=0, Req=0010, Len1=9 → Output 1,3,2,6,7,5,4,0,1. Overflow rises on the 8th step (Output=0) and stays 1 through Done.
- Req=1111 held, all Len=1 → grant order 0,1,2,3,0. Each run is 1 step, then Done, then an idle cycle. Output advances once per grant.
- Req=0100, Len2=5, drop Req[2] after 2 steps → Output stops at 3; Done=1 with Aborted=1.
- Req=0001, Len0=0 → Grant for one cycle, no Output change, Done=1 with Aborted=0.
- Assert Reset during RUN after 2 steps → next edge: all outputs 0, state IDLE, no Done pulse. Next grant goes to requester 0 first (rr pointer 0).
